// File: rtl/exec_unit.sv
// exec_unit: single-issue integer execution unit between the reservation station and the CDB.
// Accepts one instruction when idle, holds the result until the CDB grant, then broadcasts it.
`default_nettype none

module exec_unit #(
  parameter int LAT_MUL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        OutEn,
  input  logic [4:0]  opOut,
  input  logic [31:0] dataOut1,
  input  logic [31:0] dataOut2,
  input  logic [4:0]  labelOut,
  output logic        EXEable,
  output logic        CDBreq,
  input  logic        CDBgrant,
  output logic        BCEN,
  output logic [4:0]  BClabel,
  output logic [31:0] BCdata
);

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_SLT = 5'd6;
  localparam int CW = (LAT_MUL > 2) ? $clog2(LAT_MUL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [4:0]      tag;
  logic [31:0]     result;
  logic            accept;
  logic            mul_multi;

  function automatic logic [31:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_MUL:  alu = a * b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_SLT:  alu = {31'd0, ($signed(a) < $signed(b))};
      default: alu = 32'd0;
    endcase
  endfunction

  assign EXEable   = (state == IDLE);
  assign CDBreq    = (state == DONE);
  assign accept    = (state == IDLE) && OutEn;
  assign mul_multi = (opOut == OP_MUL) && (LAT_MUL > 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A zero tag means nobody is waiting on the value, so completion skips DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (OutEn) begin
          if (mul_multi)             state_next = BUSY;
          else if (labelOut == 5'd0) state_next = IDLE;
          else                       state_next = DONE;
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = (tag == 5'd0) ? IDLE : DONE;
      end
      DONE: begin
        if (CDBgrant) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tag     <= 5'd0;
      result  <= 32'd0;
      BCEN    <= 1'b0;
      BClabel <= 5'd0;
      BCdata  <= 32'd0;
    end else begin
      BCEN <= (state == DONE) && CDBgrant;
      if ((state == DONE) && CDBgrant) begin
        BClabel <= tag;
        BCdata  <= result;
      end
      if (accept) begin
        tag    <= labelOut;
        result <= alu(opOut, dataOut1, dataOut2);
        if (mul_multi) cnt <= CW'(LAT_MUL - 2);
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
